pipe_hazard_ctrl: RTL
=====================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage CPU pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and PC.
//  Resolves load-use hazards, taken-branch redirects and AXI wait stalls from the instruction and data memory masters.
//  Drives per-stage write enables and flushes. Owns the branch-redirect-pending state used while an instruction fetch is outstanding.
// PARAMETERS
//  XLEN              32  PC / branch-target width
//  LOAD_USE_BUBBLES  1   bubbles inserted per load-use hazard (legal 1..3)
//  CNT_W             32  stall performance counter width
// PORTS
//  clk               in   1     clock, all state updates on rising edge
//  rst               in   1     asynchronous, active-low reset (0 = reset)
//  ID_rs1, ID_rs2    in   5     source regs of instruction in ID
//  ID_use_rs1/rs2    in   1     ID instruction actually reads rs1/rs2
//  EX_rd             in   5     destination reg of instruction in EX
//  EX_MemRead        in   1     EX instruction is a load
//  EX_RegWrite       in   1     EX instruction writes rd
//  EX_branch_taken   in   1     EX resolved taken branch/jump (1-cycle, valid only while EX advances)
//  EX_branch_target  in   XLEN  redirect address, valid with EX_branch_taken
//  IM_stall          in   1     AXI instruction fetch outstanding
//  DM_stall          in   1     AXI data access outstanding
//  PC_write          out  1     PC register load enable
//  PC_redirect       out  1     select PC_redirect_addr as next PC
//  PC_redirect_addr  out  XLEN  redirect target
//  IFID_write/flush  out  1/1   IF/ID enable / load NOP
//  IDEX_write/flush  out  1/1   ID/EX enable / load bubble (all controls 0)
//  EXMEM_write       out  1     EX/MEM enable
//  MEMWB_write       out  1     MEM/WB enable
//  ctrl_state        out  2     FSM state: 0 RUN, 1 LU_BUBBLE, 2 FE_WAIT, 3 BE_WAIT
//  stall_cnt         out  CNT_W cycles with PC_write=0 (saturating)
// BEHAVIOUR
//  Registered state: FSM, bubble counter, redir_pend, redir_addr, stall_cnt.
//  Reset values: RUN, counter 0, redir_pend 0, redir_addr 0, stall_cnt 0.
//  Other outputs are combinational from state+inputs, 0-latency.
//  While rst=0: all *_write=0, all flushes=0, PC_redirect=0.
//  Flush dominates write: a flushed register loads NOP/bubble on the edge.
//  Default (RUN, no event): every write=1, every flush=0, PC_redirect=0.
//  Per-cycle priority, highest first:
//  1 DM_stall=1 -> BE_WAIT: all writes 0, flushes 0, EX_branch_taken ignored (EX frozen, re-presented later). redir_pend/redir_addr held. Exit when DM_stall=0: to FE_WAIT if IM_stall|redir_pend, else RUN.
//  2 EX_branch_taken & IM_stall=0: PC_redirect=1, addr=EX_branch_target, PC_write=1, IFID_flush=1, IDEX_flush=1. Any LU_BUBBLE count cancelled -> RUN.
//  3 EX_branch_taken & IM_stall=1: latch redir_pend=1, redir_addr=target. IDEX_flush=1, PC_write=0, IFID_write=0 -> FE_WAIT.
//  4 FE_WAIT or IM_stall=1: PC_write=0, IFID_write=0, IDEX_flush=1, EXMEM/MEMWB write=1.
//    - First cycle IM_stall=0 with redir_pend=1: PC_redirect=1, addr=redir_addr, PC_write=1, IFID_flush=1, IDEX_flush=1; clear redir_pend -> RUN.
//    - IM_stall=0 without pending: normal RUN cycle.
//  5 Load-use in RUN: EX_MemRead & EX_RegWrite & EX_rd!=0 & ((ID_use_rs1 & ID_rs1==EX_rd) | (ID_use_rs2 & ID_rs2==EX_rd)).
//    Response: PC_write=0, IFID_write=0, IDEX_flush=1.
//    If LOAD_USE_BUBBLES>1: -> LU_BUBBLE, count=LOAD_USE_BUBBLES-1. Each LU_BUBBLE cycle repeats the stall and decrements count; at 0 -> RUN.
//  Hazard compare is never performed against x0. A second branch_taken while redir_pend=1 overwrites redir_addr.
//  stall_cnt increments on every post-reset cycle with PC_write=0 and saturates at all-ones.
//  rst asserted mid-operation: pending redirect discarded, FSM to RUN immediately.
// TESTING
//  1 lw x5 in EX (EX_rd=5, MemRead=1), ID_rs1=5 use=1 -> exactly 1 cycle PC_write=0, IFID_write=0, IDEX_flush=1. stall_cnt=1.
//  2 Same, LOAD_USE_BUBBLES=3 -> 3 stall cycles, ctrl_state 1 for 2 cycles. EX_rd=0 case -> no stall.
//  3 Taken branch target 0x0000_0100, IM_stall=0 -> same cycle PC_redirect=1, addr 0x100, IFID_flush=IDEX_flush=1.
//  4 Taken branch 0x200 while IM_stall=1 for 4 cycles -> FE_WAIT. On IM_stall fall, PC_redirect=1 addr 0x200, IFID_flush=1, then RUN.
//  5 DM_stall=1 for 5 cycles with branch_taken high -> all writes 0, no redirect. Redirect fires on first cycle DM_stall=0. stall_cnt +5.
//  6 Reset pulse during FE_WAIT with redir_pend=1 -> outputs 0 during reset. After release: RUN, no redirect.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath (master) and the
// stall/flush sequencer (slave).
interface pipe_hazard_ctrl_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
);

  logic [4:0]      ID_rs1;
  logic [4:0]      ID_rs2;
  logic            ID_use_rs1;
  logic            ID_use_rs2;
  logic [4:0]      EX_rd;
  logic            EX_MemRead;
  logic            EX_RegWrite;
  logic            EX_branch_taken;
  logic [XLEN-1:0] EX_branch_target;
  logic            IM_stall;
  logic            DM_stall;

  logic            PC_write;
  logic            PC_redirect;
  logic [XLEN-1:0] PC_redirect_addr;
  logic            IFID_write;
  logic            IFID_flush;
  logic            IDEX_write;
  logic            IDEX_flush;
  logic            EXMEM_write;
  logic            MEMWB_write;
  logic [1:0]      ctrl_state;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output ID_rs1, ID_rs2, ID_use_rs1, ID_use_rs2,
    output EX_rd, EX_MemRead, EX_RegWrite, EX_branch_taken, EX_branch_target,
    output IM_stall, DM_stall,
    input  PC_write, PC_redirect, PC_redirect_addr,
    input  IFID_write, IFID_flush, IDEX_write, IDEX_flush,
    input  EXMEM_write, MEMWB_write, ctrl_state, stall_cnt
  );

  modport slave (
    input  ID_rs1, ID_rs2, ID_use_rs1, ID_use_rs2,
    input  EX_rd, EX_MemRead, EX_RegWrite, EX_branch_taken, EX_branch_target,
    input  IM_stall, DM_stall,
    output PC_write, PC_redirect, PC_redirect_addr,
    output IFID_write, IFID_flush, IDEX_write, IDEX_flush,
    output EXMEM_write, MEMWB_write, ctrl_state, stall_cnt
  );

endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, taken-branch
// redirects (deferred while a fetch is outstanding) and memory wait stalls.
module pipe_hazard_ctrl #(
  parameter int unsigned XLEN             = 32,
  parameter int unsigned LOAD_USE_BUBBLES = 1,
  parameter int unsigned CNT_W            = 32
) (
  input  logic              clk,
  input  logic              rst,
  pipe_hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    LU_BUBBLE = 2'd1,
    FE_WAIT   = 2'd2,
    BE_WAIT   = 2'd3
  } state_e;

  localparam logic [1:0] BUB_INIT = 2'(LOAD_USE_BUBBLES - 1);

  state_e           state_q, state_d;
  logic [1:0]       bub_q, bub_d;
  logic             redir_pend_q, redir_pend_d;
  logic [XLEN-1:0]  redir_addr_q, redir_addr_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic             pc_write;
  logic             pc_redirect;
  logic [XLEN-1:0]  pc_redirect_addr;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_write;
  logic             idex_flush;
  logic             exmem_write;
  logic             memwb_write;
  logic             load_use;
  logic             fe_ctx;

  // x0 is hard-wired zero, so a load targeting it never creates a hazard.
  assign load_use = hz.EX_MemRead && hz.EX_RegWrite && (hz.EX_rd != '0) &&
                    ((hz.ID_use_rs1 && (hz.ID_rs1 == hz.EX_rd)) ||
                     (hz.ID_use_rs2 && (hz.ID_rs2 == hz.EX_rd)));

  // Leaving BE_WAIT with a deferred redirect behaves exactly like FE_WAIT.
  assign fe_ctx = (state_q == FE_WAIT) || (state_q == BE_WAIT);

  always_comb begin
    pc_write         = 1'b1;
    pc_redirect      = 1'b0;
    pc_redirect_addr = redir_addr_q;
    ifid_write       = 1'b1;
    ifid_flush       = 1'b0;
    idex_write       = 1'b1;
    idex_flush       = 1'b0;
    exmem_write      = 1'b1;
    memwb_write      = 1'b1;
    state_d          = state_q;
    bub_d            = bub_q;
    redir_pend_d     = redir_pend_q;
    redir_addr_d     = redir_addr_q;

    if (hz.DM_stall) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      memwb_write = 1'b0;
      state_d     = BE_WAIT;
    end else if (hz.EX_branch_taken && !hz.IM_stall) begin
      pc_redirect      = 1'b1;
      pc_redirect_addr = hz.EX_branch_target;
      ifid_flush       = 1'b1;
      idex_flush       = 1'b1;
      redir_pend_d     = 1'b0;
      state_d          = RUN;
    end else if (hz.EX_branch_taken) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_flush   = 1'b1;
      redir_pend_d = 1'b1;
      redir_addr_d = hz.EX_branch_target;
      state_d      = FE_WAIT;
    end else if (hz.IM_stall) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
      state_d    = FE_WAIT;
    end else if (fe_ctx && redir_pend_q) begin
      pc_redirect  = 1'b1;
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
      redir_pend_d = 1'b0;
      state_d      = RUN;
    end else if (state_q == LU_BUBBLE) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
      bub_d      = bub_q - 2'd1;
      state_d    = (bub_d == 2'd0) ? RUN : LU_BUBBLE;
    end else if (load_use) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
      if (LOAD_USE_BUBBLES > 1) begin
        bub_d   = BUB_INIT;
        state_d = LU_BUBBLE;
      end else begin
        state_d = RUN;
      end
    end else begin
      state_d = RUN;
    end

    // Held in reset: nothing in the pipeline may load or be redirected.
    if (!rst) begin
      pc_write    = 1'b0;
      pc_redirect = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b0;
      idex_write  = 1'b0;
      idex_flush  = 1'b0;
      exmem_write = 1'b0;
      memwb_write = 1'b0;
    end

    stall_cnt_d = stall_cnt_q;
    if (!pc_write && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= RUN;
      bub_q        <= '0;
      redir_pend_q <= 1'b0;
      redir_addr_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      bub_q        <= bub_d;
      redir_pend_q <= redir_pend_d;
      redir_addr_q <= redir_addr_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign hz.PC_write         = pc_write;
  assign hz.PC_redirect      = pc_redirect;
  assign hz.PC_redirect_addr = pc_redirect_addr;
  assign hz.IFID_write       = ifid_write;
  assign hz.IFID_flush       = ifid_flush;
  assign hz.IDEX_write       = idex_write;
  assign hz.IDEX_flush       = idex_flush;
  assign hz.EXMEM_write      = exmem_write;
  assign hz.MEMWB_write      = memwb_write;
  assign hz.ctrl_state       = state_q;
  assign hz.stall_cnt        = stall_cnt_q;

endmodule
